lr35902_oam_arbiter: RTL and testbench

//  Shares the single-port OAM RAM between the CPU, the PPU sprite engine and the OAM DMA

---
 rtl/lr35902_oam_pkg.sv | 22 ++
 rtl/lr35902_oam_arbiter.sv | 126 ++++++++++++
 tb/tb_lr35902_oam_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lr35902_oam_pkg.sv
// Shared OAM definitions used by the arbiter, the DMA engine and the PPU sprite fetcher.
// Holds the owner tag type, the OAM geometry and the open-bus read value.
package lr35902_oam_pkg;

  localparam int         OAM_SIZE_DEFAULT = 160;
  localparam logic [7:0] OAM_BLOCKED_DATA = 8'hFF;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_CPU_RD,
    TAG_CPU_WR,
    TAG_PPU_RD,
    TAG_DMA_WR,
    TAG_PPU_LOST,
    TAG_CPU_BLK
  } owner_t;

  function automatic logic oam_in_range(input logic [7:0] adr, input int size);
    return int'(adr) < size;
  endfunction

endpackage

// File: rtl/lr35902_oam_arbiter.sv
// Single-port OAM arbiter: DMA > PPU > CPU, with a fixed two-cycle request/response pipeline.
// Losing or locked-out requesters still receive exactly one response, carrying BLOCKED_DATA.
module lr35902_oam_arbiter
  import lr35902_oam_pkg::*;
#(
  parameter int         OAM_SIZE     = OAM_SIZE_DEFAULT,
  parameter logic [7:0] BLOCKED_DATA = OAM_BLOCKED_DATA
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cpu_adr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_read,
  input  logic       cpu_write,
  output logic [7:0] cpu_dout,
  output logic       cpu_valid,
  output logic       cpu_block,
  input  logic [7:0] ppu_adr,
  input  logic       ppu_read,
  input  logic       ppu_lock,
  output logic [7:0] ppu_dout,
  output logic       ppu_valid,
  input  logic [7:0] dma_adr,
  input  logic [7:0] dma_din,
  input  logic       dma_write,
  input  logic       dma_active,
  output logic [7:0] oam_adr,
  output logic [7:0] oam_din,
  output logic       oam_we,
  output logic       oam_re,
  input  logic [7:0] oam_dout
);

  // stage 0 decisions
  owner_t     tag_d;
  logic [7:0] adr_d, din_d;
  logic       oor_d, we_d, re_d, cpu_req, cpu_lose, cpu_tag;
  logic       ppu_lost_d, cpu_blk_d, cpu_blk_rd_d;

  // stage 1 pipeline register (oam_* are also stage 1)
  owner_t     tag_s1;
  logic       oor_s1, ppu_lost_s1, cpu_blk_rd_s1;

  // stage 2 response state
  logic       cpu_from_ram, ppu_from_ram;
  logic [7:0] cpu_hold, ppu_hold;

  assign cpu_req = cpu_read | cpu_write;

  always_comb begin
    tag_d = TAG_NONE;
    adr_d = oam_adr;
    din_d = oam_din;
    if (dma_write) begin
      tag_d = TAG_DMA_WR;
      adr_d = dma_adr;
      din_d = dma_din;
    end else if (ppu_read) begin
      tag_d = TAG_PPU_RD;
      adr_d = ppu_adr;
    end else if (cpu_req && !ppu_lock && !dma_active) begin
      tag_d = cpu_write ? TAG_CPU_WR : TAG_CPU_RD;
      adr_d = cpu_adr;
      din_d = cpu_din;
    end
  end

  always_comb begin
    oor_d        = (tag_d != TAG_NONE) && !oam_in_range(adr_d, OAM_SIZE);
    we_d         = ((tag_d == TAG_DMA_WR) || (tag_d == TAG_CPU_WR)) && !oor_d;
    re_d         = ((tag_d == TAG_PPU_RD) || (tag_d == TAG_CPU_RD)) && !oor_d;
    cpu_tag      = (tag_d == TAG_CPU_RD) || (tag_d == TAG_CPU_WR);
    ppu_lost_d   = dma_write && ppu_read;
    // a CPU request that loses arbitration is answered like a locked-out one, never queued
    cpu_lose     = cpu_req && (ppu_lock || dma_active || dma_write || ppu_read);
    cpu_blk_d    = cpu_lose || (cpu_tag && oor_d);
    cpu_blk_rd_d = cpu_lose && !cpu_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_s1        <= TAG_NONE;
      oor_s1        <= 1'b0;
      ppu_lost_s1   <= 1'b0;
      cpu_blk_rd_s1 <= 1'b0;
      oam_adr       <= 8'h00;
      oam_din       <= 8'h00;
      oam_we        <= 1'b0;
      oam_re        <= 1'b0;
      cpu_block     <= 1'b0;
    end else begin
      tag_s1        <= tag_d;
      oor_s1        <= oor_d;
      ppu_lost_s1   <= ppu_lost_d;
      cpu_blk_rd_s1 <= cpu_blk_rd_d;
      oam_adr       <= adr_d;
      oam_din       <= din_d;
      oam_we        <= we_d;
      oam_re        <= re_d;
      cpu_block     <= cpu_blk_d;
    end
  end

  // RAM data arrives during stage 2, so dout is muxed live and captured into the hold register
  assign cpu_dout = cpu_valid ? (cpu_from_ram ? oam_dout : BLOCKED_DATA) : cpu_hold;
  assign ppu_dout = ppu_valid ? (ppu_from_ram ? oam_dout : BLOCKED_DATA) : ppu_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_valid    <= 1'b0;
      cpu_from_ram <= 1'b0;
      cpu_hold     <= BLOCKED_DATA;
      ppu_valid    <= 1'b0;
      ppu_from_ram <= 1'b0;
      ppu_hold     <= BLOCKED_DATA;
    end else begin
      cpu_valid    <= (tag_s1 == TAG_CPU_RD) || cpu_blk_rd_s1;
      cpu_from_ram <= (tag_s1 == TAG_CPU_RD) && !oor_s1;
      ppu_valid    <= (tag_s1 == TAG_PPU_RD) || ppu_lost_s1;
      ppu_from_ram <= (tag_s1 == TAG_PPU_RD) && !oor_s1;
      if (cpu_valid) cpu_hold <= cpu_dout;
      if (ppu_valid) ppu_hold <= ppu_dout;
    end
  end

endmodule

// File: tb/tb_lr35902_oam_arbiter.sv
// Bench for lr35902_oam_arbiter: synchronous OAM RAM model plus a per-request reference model
// that schedules expected N+1 / N+2 events in cycle-indexed tables.
module tb_lr35902_oam_arbiter;

  localparam int MAXC = 4096;
  localparam logic [7:0] BLK = 8'hFF;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cpu_adr = '0, cpu_din = '0, ppu_adr = '0, dma_adr = '0, dma_din = '0;
  logic       cpu_read = 0, cpu_write = 0, ppu_read = 0, ppu_lock = 0, dma_write = 0, dma_active = 0;
  logic [7:0] cpu_dout, ppu_dout, oam_adr, oam_din;
  logic       cpu_valid, cpu_block, ppu_valid, oam_we, oam_re;
  logic [7:0] oam_dout = '0;

  lr35902_oam_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_adr(cpu_adr), .cpu_din(cpu_din), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_dout(cpu_dout), .cpu_valid(cpu_valid), .cpu_block(cpu_block),
    .ppu_adr(ppu_adr), .ppu_read(ppu_read), .ppu_lock(ppu_lock),
    .ppu_dout(ppu_dout), .ppu_valid(ppu_valid),
    .dma_adr(dma_adr), .dma_din(dma_din), .dma_write(dma_write), .dma_active(dma_active),
    .oam_adr(oam_adr), .oam_din(oam_din), .oam_we(oam_we), .oam_re(oam_re), .oam_dout(oam_dout)
  );

  always #5 clk = ~clk;

  // OAM RAM: synchronous write, registered read data
  logic [7:0] init_img [256];
  logic [7:0] ram [256];
  logic       load_en = 1'b1;
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_img[i];
    end else begin
      if (oam_we) ram[oam_adr] <= oam_din;
      if (oam_re) oam_dout <= ram[oam_adr];
    end
  end

  // reference model state
  logic [7:0] mem_ref [256];
  logic       e_we [MAXC], e_re [MAXC], e_blk [MAXC], e_cv [MAXC], e_pv [MAXC];
  logic [7:0] e_adr [MAXC], e_din [MAXC], e_cd [MAXC], e_pd [MAXC];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  function automatic void clear_exp();
    for (int i = 0; i < MAXC; i++) begin
      e_we[i] = 0; e_re[i] = 0; e_blk[i] = 0; e_cv[i] = 0; e_pv[i] = 0;
      e_adr[i] = 0; e_din[i] = 0; e_cd[i] = 0; e_pd[i] = 0;
    end
  endfunction

  // Drive one request cycle, predict its consequences, then compare this cycle's outputs.
  task automatic run_cycle(input logic dw, input logic [7:0] da, input logic [7:0] dd,
                           input logic pr, input logic [7:0] pa, input logic pl, input logic dact,
                           input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd);
    int c1, c2;
    logic creq, crej;
    dma_write = dw; dma_adr = da; dma_din = dd; dma_active = dact;
    ppu_read = pr; ppu_adr = pa; ppu_lock = pl;
    cpu_read = cr; cpu_write = cw; cpu_adr = ca; cpu_din = cd;
    c1 = cyc + 1; c2 = cyc + 2;
    creq = cr | cw;
    crej = 0;
    if (dw) begin
      if (da < 8'd160) begin
        e_we[c1] = 1; e_adr[c1] = da; e_din[c1] = dd; mem_ref[da] = dd;
      end
      if (pr) begin e_pv[c2] = 1; e_pd[c2] = BLK; end
      crej = creq;
    end else if (pr) begin
      e_pv[c2] = 1;
      if (pa < 8'd160) begin
        e_re[c1] = 1; e_adr[c1] = pa; e_pd[c2] = mem_ref[pa];
      end else e_pd[c2] = BLK;
      crej = creq;
    end else if (creq) begin
      if (pl || dact || ca >= 8'd160) crej = 1;
      else if (cw) begin
        e_we[c1] = 1; e_adr[c1] = ca; e_din[c1] = cd; mem_ref[ca] = cd;
      end else begin
        e_re[c1] = 1; e_adr[c1] = ca; e_cv[c2] = 1; e_cd[c2] = mem_ref[ca];
      end
    end
    if (crej) begin
      e_blk[c1] = 1;
      if (!cw) begin e_cv[c2] = 1; e_cd[c2] = BLK; end
    end
    @(negedge clk);
    total += 5;
    if (oam_we !== e_we[cyc]) begin bad++; $display("FAIL oam_we cyc=%0d got=%b exp=%b", cyc, oam_we, e_we[cyc]); end
    if (oam_re !== e_re[cyc]) begin bad++; $display("FAIL oam_re cyc=%0d got=%b exp=%b", cyc, oam_re, e_re[cyc]); end
    if (cpu_block !== e_blk[cyc]) begin bad++; $display("FAIL cpu_block cyc=%0d got=%b exp=%b", cyc, cpu_block, e_blk[cyc]); end
    if (cpu_valid !== e_cv[cyc]) begin bad++; $display("FAIL cpu_valid cyc=%0d got=%b exp=%b", cyc, cpu_valid, e_cv[cyc]); end
    if (ppu_valid !== e_pv[cyc]) begin bad++; $display("FAIL ppu_valid cyc=%0d got=%b exp=%b", cyc, ppu_valid, e_pv[cyc]); end
    if (e_we[cyc] || e_re[cyc]) begin
      total++;
      if (oam_adr !== e_adr[cyc]) begin bad++; $display("FAIL oam_adr cyc=%0d got=%h exp=%h", cyc, oam_adr, e_adr[cyc]); end
    end
    if (e_we[cyc]) begin
      total++;
      if (oam_din !== e_din[cyc]) begin bad++; $display("FAIL oam_din cyc=%0d got=%h exp=%h", cyc, oam_din, e_din[cyc]); end
    end
    if (e_cv[cyc]) begin
      total++;
      if (cpu_dout !== e_cd[cyc]) begin bad++; $display("FAIL cpu_dout cyc=%0d got=%h exp=%h", cyc, cpu_dout, e_cd[cyc]); end
    end
    if (e_pv[cyc]) begin
      total++;
      if (ppu_dout !== e_pd[cyc]) begin bad++; $display("FAIL ppu_dout cyc=%0d got=%h exp=%h", cyc, ppu_dout, e_pd[cyc]); end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 0; load_en = 1;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (oam_we !== 0 || oam_re !== 0) begin bad++; $display("FAIL rst_en got=%b%b exp=00", oam_we, oam_re); end
    if (oam_adr !== 0 || oam_din !== 0) begin bad++; $display("FAIL rst_bus got=%h/%h exp=00/00", oam_adr, oam_din); end
    if (cpu_valid !== 0 || ppu_valid !== 0 || cpu_block !== 0) begin bad++; $display("FAIL rst_pulse got=%b%b%b exp=000", cpu_valid, ppu_valid, cpu_block); end
    if (cpu_dout !== BLK || ppu_dout !== BLK) begin bad++; $display("FAIL rst_dout got=%h/%h exp=ff/ff", cpu_dout, ppu_dout); end
    load_en = 0; reset_n = 1;
    cyc = 0;
  endtask

  task automatic test_cpu_read();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    idle(3);
    total++;
    if (cpu_dout !== 8'h5A) begin bad++; $display("FAIL cpu_rd_hold got=%h exp=5a", cpu_dout); end
  endtask

  task automatic test_dma_block();
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0, 1, 8'h04, 8'h22);
    idle(2);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h04, 0);
    idle(3);
    total++;
    if (cpu_dout !== 8'h3C) begin bad++; $display("FAIL dma_block_ram got=%h exp=3c", cpu_dout); end
  endtask

  task automatic test_ppu_lost();
    run_cycle(1, 8'h08, 8'h77, 1, 8'h08, 0, 1, 0, 0, 0, 0);
    idle(2);
    run_cycle(0, 0, 0, 1, 8'h08, 0, 0, 0, 0, 0, 0);
    idle(3);
    total++;
    if (ppu_dout !== 8'h77) begin bad++; $display("FAIL ppu_after_dma got=%h exp=77", ppu_dout); end
  endtask

  task automatic test_out_of_range();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hA0, 0);
    run_cycle(0, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hB0, 8'h11);
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 1, 8'(i), 0, 0, 0, 0, 0, 0);
    idle(3);
    total++;
    if (ppu_dout !== init_img[3]) begin bad++; $display("FAIL ppu_b2b_last got=%h exp=%h", ppu_dout, init_img[3]); end
  endtask

  task automatic test_lock();
    run_cycle(0, 0, 0, 0, 0, 1, 0, 1, 0, 8'h20, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h21, 0);
    run_cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 8'h22, 0, 0, 1, 1, 8'h22, 8'h99);
    idle(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_cycle($urandom_range(0, 3) == 0, 8'($urandom_range(0, 175)), 8'($urandom),
                $urandom_range(0, 2) == 0, 8'($urandom_range(0, 175)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
                8'($urandom_range(0, 175)), 8'($urandom));
    end
    idle(3);
  endtask

  task automatic test_reset_midflight();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    reset_n = 0;
    #1;
    total += 3;
    if (oam_re !== 0 || oam_adr !== 0) begin bad++; $display("FAIL midrst_bus got=%b/%h exp=0/00", oam_re, oam_adr); end
    if (cpu_dout !== BLK) begin bad++; $display("FAIL midrst_dout got=%h exp=ff", cpu_dout); end
    if (cpu_valid !== 0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", cpu_valid); end
    clear_exp();
    @(posedge clk); #1;
    reset_n = 1;
    cyc = 0;
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
    init_img[8'h10] = 8'h5A;
    init_img[8'h04] = 8'h3C;
    for (int i = 0; i < 256; i++) mem_ref[i] = init_img[i];
    clear_exp();
    test_reset();
    test_cpu_read();
    test_dma_block();
    test_ppu_lost();
    test_out_of_range();
    test_back_to_back();
    test_lock();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
